// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_display_pkg
//  Description : Shared types and constants for the hex display feeder.
//                Holds the feeder FSM state encoding, the nibble width and the
//                largest supported digit count.
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } feeder_state_t;

endpackage : hex_display_pkg
`default_nettype wire

// File: rtl/blink_timer.sv
`default_nettype none
// ============================================================================
//  Module      : blink_timer
//  Description : Blink phase generator. While piscar is high a counter runs
//                0..BLINK_DIV-1 and fase toggles each time it wraps. Dropping
//                piscar clears counter and phase on the next edge.
//  Ports       : clock  - rising-edge clock
//                reset  - synchronous active-high reset
//                piscar - blink request
//                fase   - blink phase (1 = blank the display)
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_timer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic piscar,
    output logic fase
);

    localparam int c_cnt_w = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_fase;

    always_ff @(posedge clock) begin
        if (reset || !piscar) begin
            r_cnt  <= '0;
            r_fase <= 1'b0;
        end else if (r_cnt == c_cnt_w'(BLINK_DIV - 1)) begin
            r_cnt  <= '0;
            r_fase <= ~r_fase;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign fase = r_fase;

endmodule : blink_timer
`default_nettype wire

// File: rtl/hex_display_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : hex_display_feeder
//  Description : Feeds a bank of per-digit hex-to-7-segment decoders. Accepts
//                a 32-bit value over valid/ready, scans its nibbles from the
//                most significant digit down to compute leading-zero
//                suppression, then commits all nibbles and per-digit enables
//                in a single edge. Digit 0 is never suppressed.
//  Ports       : clock   - rising-edge clock
//                reset   - synchronous active-high reset
//                valor   - value to display (bits above 4*N_DIGITS ignored)
//                valido  - valor is valid
//                pronto  - ready; transfer on valido && pronto
//                digito  - committed nibbles, digit 0 least significant
//                modo    - committed per-digit enable (0 shows "-")
//                piscar  - blink request (HEX_BLINK_EN builds only)
//  Config      : define HEX_BLINK_EN to add the piscar input and blink timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_display_feeder
    import hex_display_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  valor,
    input  logic                         valido,
    output logic                         pronto,
    output logic [NIBBLE_W*N_DIGITS-1:0] digito,
    output logic [N_DIGITS-1:0]          modo
`ifdef HEX_BLINK_EN
    ,
    input  logic                         piscar
`endif
);

    localparam int c_val_w = NIBBLE_W * N_DIGITS;
    localparam int c_idx_w = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    // Parameter sanity checks, evaluated at elaboration.
    if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS) begin : g_bad_n_digits
        $error("hex_display_feeder: N_DIGITS must be in 1..8");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("hex_display_feeder: BLINK_DIV must be >= 2");
    end

    feeder_state_t        r_state;
    feeder_state_t        w_state_next;

    logic [c_val_w-1:0]   r_shadow;
    logic [N_DIGITS-1:0]  r_modo_sh;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_zeros;
    logic [c_val_w-1:0]   r_digito;
    logic [N_DIGITS-1:0]  r_modo;

    logic                 w_take;
    logic [NIBBLE_W-1:0]  w_nib;
    logic                 w_nib_zero;
    logic                 w_last;

    assign w_nib      = r_shadow[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_nib_zero = (w_nib == '0);
    assign w_last     = (r_idx == '0);

    // ------------------------------------------------------------------
    // Next-state and handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        pronto       = 1'b0;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                pronto = 1'b1;
                w_take = valido;
                if (valido) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (w_last) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Scan datapath. The shadow registers are only meaningful between a
    // transfer and its commit, so they need no reset; the visible outputs
    // are reset so a mid-scan reset blanks the display immediately.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_take) begin
            r_shadow <= valor[c_val_w-1:0];
            r_idx    <= c_idx_w'(N_DIGITS - 1);
            r_zeros  <= 1'b1;
        end else if (r_state == SCAN) begin
            // Suppress while still inside the leading-zero run; digit 0 is
            // always shown so a zero value reads "-------0".
            r_modo_sh[r_idx] <= !(r_zeros && w_nib_zero && !w_last);
            if (!w_nib_zero) begin
                r_zeros <= 1'b0;
            end
            if (!w_last) begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_digito <= '0;
            r_modo   <= '0;
        end else if (r_state == COMMIT) begin
            r_digito <= r_shadow;
            r_modo   <= r_modo_sh;
        end
    end

    assign digito = r_digito;

`ifdef HEX_BLINK_EN
    logic w_fase;

    blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .clock  (clock),
        .reset  (reset),
        .piscar (piscar),
        .fase   (w_fase)
    );

    // Blanking only masks the output; the committed enables are kept.
    assign modo = w_fase ? '0 : r_modo;
`else
    assign modo = r_modo;
`endif

endmodule : hex_display_feeder
`default_nettype wire

// File: doc/hex_display_feeder.md
# hex_display_feeder

Upstream feeder for the bank of per-digit hex-to-7-segment decoders. It accepts a 32-bit value over a valid/ready handshake and scans its nibbles sequentially from the most significant digit down, computing leading-zero suppression. It then commits all digit nibbles and per-digit `modo` enables atomically. Each decoder instance `i` takes `digito[4i+3:4i]` and `modo[i]`. `modo[i]=0` makes that decoder show "-".

## Interface
- `N_DIGITS`, 8: number of displayed digits (1..8); uses `valor[4*N_DIGITS-1:0]`.
- `BLINK_DIV`, 25_000_000: clock cycles per blink half-period. Used only with `HEX_BLINK_EN`; ≥2.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `valor`  in  32  value to display.
- `valido`  in  1  `valor` is valid.
- `pronto`  out  1  ready; a transfer occurs on an edge where `valido && pronto`.
- `digito`  out  4*N_DIGITS  committed nibbles; digit 0 is least significant.
- `modo`  out  N_DIGITS  committed per-digit enable for the decoders.
- `piscar`  in  1  blink request. Present only with `HEX_BLINK_EN`.

## Operation
- FSM states: IDLE, SCAN, COMMIT. Reset state is IDLE.
- IDLE:
  - `pronto=1`.
  - On transfer: capture `valor` into shadow, set `idx=N_DIGITS-1`, set `zeros=1`, go to SCAN.
- SCAN: one digit per cycle, at index `idx`. Let `nib` be the shadow nibble at `idx`.
  - `modo_sh[idx] = !(zeros && nib==0 && idx!=0)`.
  - If `nib!=0`, clear `zeros`.
  - If `idx==0`, go to COMMIT; otherwise decrement `idx`.
- COMMIT:
  - Copy shadow to `digito` and `modo_sh` to `modo` in the same edge.
  - Go to IDLE.
- `pronto=0` in SCAN and COMMIT. `valido` is ignored there and no transfer is recorded.
- Digit 0 is never suppressed, so a value of 0 displays "-------0".
- Nibbles above the first non-zero digit are suppressed. Zero nibbles below it are displayed.
- `valor` bits above `4*N_DIGITS` are ignored.

## Timing
- Reset values: state IDLE, `pronto=1`, `digito=0`, `modo=0` (all dashes), blink counter and phase 0.
- Latency: for a transfer on edge E0, `digito` and `modo` update on edge E(N_DIGITS+1). That is 9 edges for the default.
- `pronto` returns high on the same edge as the commit. A new transfer can occur on the next edge.
- Sustained throughput is one value per N_DIGITS+2 cycles.
- Outputs hold their previous committed values during SCAN, so there is no partial update.
- Reset asserted mid-SCAN or in COMMIT:
  - Aborts the scan and discards the shadow.
  - Outputs take their reset values on that edge.
- `valido` may drop before acceptance. No value is latched unless a transfer edge occurs.

## Configuration
- Macro `HEX_BLINK_EN`.
- When defined:
  - Adds the `piscar` input.
  - While `piscar=1`, a counter counts 0..BLINK_DIV-1 and toggles `fase` on wrap.
  - When `fase=1`, the `modo` output is forced to all 0 and the committed value is retained internally.
  - `piscar=0` clears the counter and `fase` on the next edge.
- When undefined: no `piscar` port and no counter; `modo` equals the committed enables.

## Structure
- Package `hex_display_pkg`:
  - State enum (IDLE/SCAN/COMMIT).
  - `NIBBLE_W=4`.
  - `MAX_DIGITS=8`.
- Sub-module `blink_timer`, instantiated only under `HEX_BLINK_EN`.
  - Inputs: `clock`, `reset`, `piscar`. Output: `fase`.
  - Parameter: `BLINK_DIV`.

## Test plan
- Reset, then transfer `valor=32'h0000_1A30`. After 9 edges: `digito=32'h00001A30`, `modo=8'b0000_1111`, and `pronto` is high again.
- Transfer `32'h0` → `modo=8'b0000_0001`. Transfer `32'hF000_0000` → `modo=8'hFF`.
- Hold `valido=1` with a changing `valor` during SCAN. Only the first value is committed, and outputs stay at the old value until the commit edge.
- Assert `reset` on the 4th SCAN cycle → `digito=0`, `modo=0`, `pronto=1` on that edge, and no later commit.
- With `HEX_BLINK_EN` and `BLINK_DIV=4`, `piscar=1` after committing `32'h12`:
  - `modo` alternates between `8'b0000_0011` and 0 every 4 cycles.
  - `piscar=0` restores `8'b0000_0011` on the next edge.
- With `N_DIGITS=4`, transfer `32'hABCD_0042` → `digito=16'h0042`, `modo=4'b0011`, commit after 5 edges.
